// File: rtl/hsv2rgb_stream.sv
// HSV to RGB pixel stream converter: four-register pipeline with valid/ready
// handshake, per-pixel bypass and a sideband tag carried alongside each pixel.
module hsv2rgb_stream #(
    parameter int DW = 8,
    parameter int UW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*DW-1:0] hsv_in,
    input  logic            bypass_in,
    input  logic [UW-1:0]   user_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] rgb_out,
    output logic [UW-1:0]   user_out
);

    localparam logic [2*DW:0] HALF = (2*DW+1)'(1) << (DW-1);

    // round(a*b/M) with M = 2^DW-1, exact for all DW-bit operands
    function automatic logic [DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW:0] y;
        y = ({{(DW+1){1'b0}}, a} * {{(DW+1){1'b0}}, b}) + HALF;
        return DW'((y + (y >> DW)) >> DW);
    endfunction

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || rst;

    // S0: unpacked input
    logic            s0_valid;
    logic [DW-1:0]   s0_h, s0_s, s0_v;
    logic            s0_byp;
    logic [UW-1:0]   s0_user;

    // S1: hue split into sector and fraction
    logic            s1_valid;
    logic [2:0]      s1_sector;
    logic [DW-1:0]   s1_f, s1_h, s1_s, s1_v;
    logic            s1_byp;
    logic [UW-1:0]   s1_user;

    // S2: p/q/t terms
    logic            s2_valid;
    logic [2:0]      s2_sector;
    logic [DW-1:0]   s2_v, s2_p, s2_q, s2_t;
    logic [3*DW-1:0] s2_raw;
    logic            s2_byp;
    logic [UW-1:0]   s2_user;

    logic [DW+2:0]   h6;
    logic [DW-1:0]   s_f, s_nf, p_n, q_n, t_n;
    logic [3*DW-1:0] rgb_n;

    assign h6 = {3'b000, s0_h} * (DW+3)'(6);

    assign s_f  = mul(s1_s, s1_f);
    assign s_nf = mul(s1_s, ~s1_f);
    assign p_n  = mul(s1_v, ~s1_s);
    assign q_n  = mul(s1_v, ~s_f);
    assign t_n  = mul(s1_v, ~s_nf);

    always_comb begin
        rgb_n = {s2_v, s2_t, s2_p};
        case (s2_sector)
            3'd0:    rgb_n = {s2_v, s2_t, s2_p};
            3'd1:    rgb_n = {s2_q, s2_v, s2_p};
            3'd2:    rgb_n = {s2_p, s2_v, s2_t};
            3'd3:    rgb_n = {s2_p, s2_q, s2_v};
            3'd4:    rgb_n = {s2_t, s2_p, s2_v};
            3'd5:    rgb_n = {s2_v, s2_p, s2_q};
            default: rgb_n = {s2_v, s2_t, s2_p};
        endcase
        if (s2_byp)
            rgb_n = s2_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s0_valid  <= in_valid;
            s1_valid  <= s0_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Data registers need no reset: bubbles are marked by the valid bits.
    always_ff @(posedge clk) begin
        if (adv) begin
            s0_h      <= hsv_in[3*DW-1:2*DW];
            s0_s      <= hsv_in[2*DW-1:DW];
            s0_v      <= hsv_in[DW-1:0];
            s0_byp    <= bypass_in;
            s0_user   <= user_in;

            s1_sector <= h6[DW+2:DW];
            s1_f      <= h6[DW-1:0];
            s1_h      <= s0_h;
            s1_s      <= s0_s;
            s1_v      <= s0_v;
            s1_byp    <= s0_byp;
            s1_user   <= s0_user;

            s2_sector <= s1_sector;
            s2_v      <= s1_v;
            s2_p      <= p_n;
            s2_q      <= q_n;
            s2_t      <= t_n;
            s2_raw    <= {s1_h, s1_s, s1_v};
            s2_byp    <= s1_byp;
            s2_user   <= s1_user;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out  <= '0;
            user_out <= '0;
        end else if (adv) begin
            rgb_out  <= rgb_n;
            user_out <= s2_user;
        end
    end

endmodule

// File: tb/tb_hsv2rgb_stream.sv
// Bench for hsv2rgb_stream (DW=8, UW=4): directed vector table, handshake
// corner sequences and a random stream checked against a reference model.
module tb_hsv2rgb_stream;

    localparam int DW = 8;
    localparam int UW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   hsv_in;
    logic          bypass_in;
    logic [3:0]    user_in;
    logic          out_valid;
    logic          out_ready;
    logic [23:0]   rgb_out;
    logic [3:0]    user_out;

    always #5 clk = ~clk;

    hsv2rgb_stream #(.DW(DW), .UW(UW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hsv_in    (hsv_in),
        .bypass_in (bypass_in),
        .user_in   (user_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rgb_out   (rgb_out),
        .user_out  (user_out)
    );

    typedef struct {
        logic [23:0] rgb;
        logic [3:0]  user;
    } exp_t;

    typedef struct {
        logic [7:0]  h, s, v;
        logic        byp;
        logic [3:0]  user;
        logic [23:0] exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sb_en;
    bit          accepted;
    bit          prev_stall;
    logic [23:0] prev_rgb;
    logic [3:0]  prev_user;
    exp_t        exp_q[$];
    vec_t        vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rmul(input int a, input int b);
        return (a * b + 127) / 255;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] px, input logic byp);
        int h, s, v, h6, sec, f, p, q, t, r, g, b;
        if (byp)
            return px;
        h = int'(px[23:16]);
        s = int'(px[15:8]);
        v = int'(px[7:0]);
        h6  = h * 6;
        sec = h6 / 256;
        f   = h6 % 256;
        p = rmul(v, 255 - s);
        q = rmul(v, 255 - rmul(s, f));
        t = rmul(v, 255 - rmul(s, 255 - f));
        case (sec)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // One clock: inputs already set at the negedge; samples 1 ns later.
    task automatic tick();
        exp_t e;
        #1;
        accepted = !rst && in_valid && in_ready;
        if (!rst && prev_stall) begin
            check("hold_rgb", rgb_out, prev_rgb);
            check("hold_user", user_out, prev_user);
        end
        if (!rst && out_valid && !out_ready)
            check("in_ready_stall", in_ready, 0);
        prev_stall = !rst && out_valid && !out_ready;
        prev_rgb   = rgb_out;
        prev_user  = user_out;
        if (sb_en) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got rgb %06h user %0h, expected none", rgb_out, user_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_rgb", rgb_out, e.rgb);
                        check("sb_user", user_out, e.user);
                    end
                end
                if (accepted) begin
                    e.rgb  = model(hsv_in, bypass_in);
                    e.user = user_in;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [23:0] px, input logic byp, input logic [3:0] u);
        int n = 0;
        in_valid  = 1'b1;
        hsv_in    = px;
        bypass_in = byp;
        user_in   = u;
        tick();
        while (!accepted && n < 100) begin
            tick();
            n++;
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: pixel %06h not accepted in 100 cycles", px);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            tick();
        repeat (6) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int lat, k, sent, cyc;

        vecs[0] = '{8'd0,   8'd255, 8'd255, 1'b0, 4'h1, 24'hFF0000};
        vecs[1] = '{8'd85,  8'd255, 8'd255, 1'b0, 4'h2, 24'h01FF00};
        vecs[2] = '{8'd170, 8'd255, 8'd255, 1'b0, 4'h3, 24'h0003FF};
        vecs[3] = '{8'd43,  8'd128, 8'd100, 1'b0, 4'h4, 24'h646432};
        vecs[4] = '{8'd200, 8'd255, 8'd128, 1'b0, 4'h5, 24'h580080};
        vecs[5] = '{8'd255, 8'd255, 8'd255, 1'b0, 4'h6, 24'hFF0005};
        vecs[6] = '{8'h12,  8'h34,  8'h56,  1'b1, 4'h7, 24'h123456};
        vecs[7] = '{8'd77,  8'd0,   8'd200, 1'b0, 4'h8, 24'hC8C8C8};
        vecs[8] = '{8'd0,   8'd0,   8'd0,   1'b0, 4'h9, 24'h000000};

        rst        = 1'b1;
        in_valid   = 1'b1;
        hsv_in     = 24'hFFFFFF;
        bypass_in  = 1'b0;
        user_in    = 4'hF;
        out_ready  = 1'b0;
        sb_en      = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_rgb_out", rgb_out, 0);
        check("rst_user_out", user_out, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table, one pixel at a time, latency measured per vector
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 check("first_accept_ready", in_ready, 1);
        for (int i = 0; i < 9; i++) begin
            in_valid  = 1'b1;
            hsv_in    = {vecs[i].h, vecs[i].s, vecs[i].v};
            bypass_in = vecs[i].byp;
            user_in   = vecs[i].user;
            tick();
            check("vec_accept", accepted, 1);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check("vec_latency", lat, 3);
            check("vec_rgb", rgb_out, vecs[i].exp);
            check("vec_user", user_out, vecs[i].user);
            tick();
        end

        // S = 0 hue sweep
        sb_en = 1'b1;
        for (int h = 0; h < 256; h++)
            send({8'(h), 8'd0, 8'd200}, 1'b0, 4'(h));
        drain();

        // 8-pixel stream with a 10-cycle downstream stall in the middle
        k = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c < 14);
            if (k < 8) begin
                in_valid  = 1'b1;
                hsv_in    = {8'(k * 31), 8'd180, 8'd240};
                bypass_in = 1'b0;
                user_in   = 4'(k + 3);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted)
                k++;
        end
        check("stall_all_sent", k, 8);
        drain();

        // Bypass pixels interleaved with HSV pixels
        for (int i = 0; i < 4; i++) begin
            send(24'h123456, 1'b1, 4'(2 * i));
            send({8'(i * 60), 8'd200, 8'd150}, 1'b0, 4'(2 * i + 1));
        end
        drain();

        // Reset with three pixels in flight
        send(24'h00FFFF, 1'b0, 4'hA);
        send(24'h55FFFF, 1'b0, 4'hB);
        send(24'hAAFFFF, 1'b0, 4'hC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_flush_valid", out_valid, 0);
        send(24'h2B8064, 1'b0, 4'hD);
        drain();

        // Random stream
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid  = 1'b1;
                hsv_in    = 24'($urandom);
                bypass_in = ($urandom_range(0, 15) == 0);
                user_in   = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cyc++;
            if (accepted) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        check("random_sent", sent, 10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv2rgb_stream.md
HSV2RGB_STREAM -- requirements
Module: hsv2rgb_stream

Interface
REQ-001 SHALL have parameter DW, default 8, giving the per-channel width of H, S, V, R, G and B (legal range 4..12).
REQ-002 SHALL have parameter UW, default 1, giving the width of the sideband tag carried alongside each pixel.
REQ-003 SHALL have port clk  in  1  system clock; the block has one clock and all logic is clocked on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  input pixel present.
REQ-006 SHALL have port in_ready  out  1  block accepts the input pixel this cycle.
REQ-007 SHALL have port hsv_in  in  3*DW  input pixel packed as {H, S, V}, with H in the MSBs; all fields unsigned, full scale = 2^DW-1.
REQ-008 SHALL have port bypass_in  in  1  per-pixel mode; 1 = treat hsv_in as {R, G, B} and pass it through unchanged.
REQ-009 SHALL have port user_in  in  UW  sideband tag.
REQ-010 SHALL have port out_valid  out  1  output pixel present.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the output pixel.
REQ-012 SHALL have port rgb_out  out  3*DW  output pixel packed as {R, G, B}.
REQ-013 SHALL have port user_out  out  UW  tag, matching the pixel on rgb_out.

Function
REQ-014 SHALL transfer an input pixel on any rising edge where in_valid && in_ready; the same rule applies to out_valid && out_ready at the output.
REQ-015 SHALL be a 4-register pipeline (S0 unpack, S1 hue scaling, S2 p/q/t, S3 sector mux/output) with a valid bit per stage.
REQ-016 SHALL advance all stages together on adv = !out_valid || out_ready, and SHALL hold every stage when adv = 0.
REQ-017 SHALL drive in_ready = adv; the combinational path from out_ready to in_ready is intentional.
REQ-018 SHALL give a latency of: pixel accepted at edge N appears on rgb_out/out_valid after edge N+3 when out_ready is held high, at a throughput of 1 pixel/clk.
REQ-019 SHALL propagate bubbles as invalid stages; bubbles do not collapse.
REQ-020 SHALL keep rgb_out and user_out stable while out_valid && !out_ready.
REQ-021 SHALL compute h6 = H*6 at width DW+3; sector = h6[DW+2:DW] (always 0..5 for H < 2^DW); f = h6[DW-1:0].
REQ-022 SHALL define M = 2^DW-1 and mul(a,b) = round(a*b/M), computed exactly as y = a*b + 2^(DW-1), result = (y + (y>>DW)) >> DW, giving a DW-bit result.
REQ-023 SHALL compute p = mul(V, M-S), q = mul(V, M-mul(S,f)) and t = mul(V, M-mul(S, M-f)).
REQ-024 SHALL map sector to {R,G,B} as: 0 -> {V,t,p}; 1 -> {q,V,p}; 2 -> {p,V,t}; 3 -> {p,q,V}; 4 -> {t,p,V}; 5 -> {V,p,q}.
REQ-025 SHALL, for S = 0, produce R = G = B = V for every H.
REQ-026 SHALL, for pixels with bypass_in = 1, output hsv_in unchanged with identical latency and ordering.
REQ-027 SHALL carry user_in and bypass_in through the pipeline in lockstep with their pixel.
REQ-028 SHALL never saturate or wrap any arithmetic result; all intermediate values fit their widths for all inputs.

Reset
REQ-029 SHALL, while rst = 1, clear all stage valid bits, drive out_valid = 0, and reset rgb_out and user_out to 0.
REQ-030 SHALL drive in_ready = 1 during reset and accept nothing while rst = 1.
REQ-031 SHALL discard in-flight pixels when rst is asserted mid-stream; no stale pixel appears after reset is released.
REQ-032 SHALL accept a pixel on the first edge after rst deasserts.

Verification (DW=8)
REQ-033 Bench SHALL cover: H=0, S=255, V=255, out_ready=1 -> rgb_out={255,0,0}, out_valid exactly 3 edges after acceptance.
REQ-034 Bench SHALL cover: H=85, S=255, V=255 -> {1,255,0}; and H=170, S=255, V=255 -> {0,3,255}.
REQ-035 Bench SHALL cover: S=0, V=200, with H swept 0..255 -> every output is {200,200,200}.
REQ-036 Bench SHALL cover: a stream of 8 pixels with out_ready low for 10 cycles mid-stream -> in_ready low while out_valid && !out_ready, output held stable, all 8 pixels delivered in order with correct user_out.
REQ-037 Bench SHALL cover: bypass_in=1 with hsv_in=0x123456 interleaved with HSV pixels -> 0x123456 out in sequence.
REQ-038 Bench SHALL cover: rst pulsed for 1 cycle with 3 pixels in flight -> out_valid=0 on the next cycle and none of the 3 pixels ever output; a new pixel sent right after reset is output normally.
REQ-039 Bench SHALL run a random test of 10k pixels with random in_valid/out_ready against a bit-exact model of REQ-021..REQ-024.
